// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame size, widths, output-streamer state encoding
// and the 3-bit bit-reverse helper.
package fft_pkg;

   localparam int N_POINTS = 8;
   localparam int ADDR_W   = 3;
   localparam int DATA_W   = 32;

   typedef enum logic {
      OS_IDLE,
      OS_STREAM
   } out_state_t;

   function automatic logic [ADDR_W-1:0] bitrev3(input logic [ADDR_W-1:0] a);
      return {a[0], a[1], a[2]};
   endfunction

endpackage

// File: rtl/fft_out_streamer.sv
// Drains the 8-point FFT result buffer as a valid/ready stream of complex bins.
// Optional macro FFT_OUT_BITREV_EN: fetch bins from bit-reversed buffer addresses.
module fft_out_streamer
   import fft_pkg::*;
#(
   parameter int DATA_W = fft_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [2:0]        rd_addr_out,
   input  logic [DATA_W-1:0] rd_re_out,
   input  logic [DATA_W-1:0] rd_im_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_re,
   output logic [DATA_W-1:0] out_im,
   output logic [2:0]        out_idx,
   output logic              out_last
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);
   localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'(N_POINTS - 2);

   out_state_t        state;
   logic [ADDR_W-1:0] cnt;

   function automatic logic [ADDR_W-1:0] addr_map(input logic [ADDR_W-1:0] k);
`ifdef FFT_OUT_BITREV_EN
      return bitrev3(k);
`else
      return k;
`endif
   endfunction

   // Prefetch address: the bin after the one held in the output register.
   // At cnt==7 it wraps to map(0); nothing is fetched there.
   assign rd_addr_out = (state == OS_STREAM) ? addr_map(cnt + ADDR_W'(1))
                                             : addr_map('0);

   assign out_idx = cnt;

   // Valid/ready: a bin transfers on any rising edge where out_valid and
   // out_ready are both high; while out_valid && !out_ready the bin holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= OS_IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            OS_IDLE: begin
               if (start) begin
                  state     <= OS_STREAM;
                  out_re    <= rd_re_out;
                  out_im    <= rd_im_out;
                  cnt       <= '0;
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
                  out_last  <= 1'b0;
               end
            end
            OS_STREAM: begin
               // out_valid is always high here, so out_ready alone is the handshake.
               if (out_ready) begin
                  if (cnt == LAST_IDX) begin
                     state     <= OS_IDLE;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     cnt       <= '0;
                     out_last  <= 1'b0;
                  end else begin
                     out_re   <= rd_re_out;
                     out_im   <= rd_im_out;
                     cnt      <= cnt + ADDR_W'(1);
                     out_last <= (cnt == PRE_LAST);
                  end
               end
            end
            default: state <= OS_IDLE;
         endcase
      end
   end

endmodule

// File: doc/fft_out_streamer.md
# fft_out_streamer

Drains the 8-point FFT result buffer once the butterfly engine finishes a frame. Drives the buffer's output read address (`rd_addr_out`) and takes the combinational read data back (`rd_re_out`/`rd_im_out`). Emits the eight complex IEEE-754 single-precision bins as a valid/ready stream toward the host interface. It is the read-side counterpart of the buffer's load port, and sits between the FFT controller and the output bus.

## Interface

Parameters:
- `N_POINTS`, 8: samples per frame; fixed, taken from the shared package.
- `DATA_W`, 32: width of each real or imaginary word.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse from the controller: the frame in the buffer is final.
- `busy`  out  1  high while a frame is being streamed.
- `done`  out  1  one-cycle pulse after the last bin is accepted.
- `rd_addr_out`  out  3  read address to the buffer's output port.
- `rd_re_out`  in  32  buffer read data, real; combinational from `rd_addr_out`.
- `rd_im_out`  in  32  buffer read data, imaginary.
- `out_valid`  out  1  output register holds a valid bin.
- `out_ready`  in  1  downstream accepts the bin.
- `out_re`  out  32  bin real part.
- `out_im`  out  32  bin imaginary part.
- `out_idx`  out  3  frequency index k of the presented bin (0..7).
- `out_last`  out  1  high with `out_valid` when `out_idx` is 7.

## Operation

- FSM has two states:
  - IDLE → STREAM on `start`.
  - STREAM → IDLE on a handshake (`out_valid & out_ready`) while `out_idx`=7.
- Counter `cnt` (3 bit) holds the index k of the bin currently in the output register.
- Address map: `rd_addr_out` = map(0) in IDLE and map(`cnt`+1) in STREAM. At `cnt`=7 the address wraps to map(0); the value is don't-care because no fetch happens.
- Start: at the `start` edge in IDLE:
  - capture `rd_re_out`/`rd_im_out` into `out_re`/`out_im`;
  - set `cnt`=0, `out_valid`=1, `busy`=1.
- Advance: on a handshake with `cnt`<7, capture the bank data at map(`cnt`+1) and increment `cnt`. `out_valid` stays high, so back-to-back bins stream at 1 bin/cycle.
- Last bin: on the handshake with `cnt`=7:
  - `out_valid`→0, `busy`→0;
  - `done`=1 for exactly the next cycle;
  - `cnt`→0.
- Backpressure: while `out_valid & !out_ready`, `out_re`, `out_im`, `out_idx` and `out_last` hold stable.
- `start` while in STREAM is ignored and does not restart the frame.
- `start` during the `done` cycle (already IDLE) is accepted.
- `out_ready` high while `out_valid` is low has no effect.
- The controller must not write the buffer (load/writeback) while `busy`=1. The block does not check this.
- `out_idx` = `cnt`; `out_last` = `out_valid & (cnt==7)`.

## Timing

- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_re`=0, `out_im`=0, `out_idx`=0, `out_last`=0. `rd_addr_out` = map(0) = 0; state IDLE; `cnt`=0.
- Latency: `start` sampled at edge T → bin 0 valid from edge T.
- Full frame with `out_ready` held high: 8 cycles of `out_valid`, then `done` in cycle 9.
- Reset asserted mid-frame: all outputs return to reset values immediately, the frame is abandoned, and no `done` is produced.
- Registers: all outputs except `rd_addr_out` are driven directly from flops. `rd_addr_out` is combinational from state and `cnt`.

## Configuration

- `FFT_OUT_BITREV_EN` defined:
  - map(k) = bit-reverse of k, so reads follow 0,4,2,6,1,5,3,7;
  - used when the butterfly writes results in bit-reversed order;
  - `out_idx` still counts 0..7 in natural frequency order.
- Not defined: map(k) = k, natural address order.

## Structure

- Shared package `fft_pkg` holds:
  - `N_POINTS`=8, `ADDR_W`=3, `DATA_W`=32;
  - the state enum `out_state_t` {`OS_IDLE`, `OS_STREAM`};
  - a `bitrev3` function.
- No sub-module; the address map is a package function call.

## Test plan

- Buffer loaded with re[i]=i, im[i]=100+i, `out_ready`=1, macro undefined, `start` → bins k=0..7 with `out_re`=0..7 and `out_im`=100..107 on consecutive cycles. `out_last` high only on k=7; `done` pulses in the cycle after.
- Same buffer, `FFT_OUT_BITREV_EN` defined → `out_re` sequence 0,4,2,6,1,5,3,7; `out_idx` sequence 0..7.
- `out_ready` low for 3 cycles at k=2 → `out_re`=2 and `out_idx`=2 held stable for those cycles; stream resumes at k=3 with no loss or duplicate.
- `start` re-pulsed at k=4 → ignored; frame completes 0..7 with a single `done`. A `start` in the `done` cycle begins a new frame at k=0 on the next cycle.
- `rst_n` pulsed low at k=5 → `out_valid`, `busy` and `out_re` drop to 0 asynchronously; no `done`; the next `start` streams from k=0.
- Random `out_ready` over 1000 frames → every frame delivers exactly 8 bins in order and exactly one `done`.
